vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
Parametrised raster timing generator, successor to the fixed 640x480 VGA controller.
- Single system clock with an internal pixel clock-enable divider; no derived clock net.
- Every timing field and sync polarity is a parameter.
- Outputs are registered: h/v sync, display enable, pixel coordinates, pixel strobe, line-start and frame-start pulses.
- Sits between the system clock domain and the pixel pipeline / DAC driver.

Parameters:
- CLK_DIV, 4, system clocks per pixel (>=1; 1 = strobe every clock)
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_SYNC_POL, 0, active level of h_sync_o (0 = active-low)
- V_SYNC_POL, 0, active level of v_sync_o

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- en_i  in  1  run enable; low = synchronous return to reset state
- pix_en_o  out  1  one-clock strobe, first clock of each new pixel
- h_sync_o  out  1  horizontal sync, polarity per H_SYNC_POL
- v_sync_o  out  1  vertical sync, polarity per V_SYNC_POL
- de_o  out  1  display enable (active region)
- x_o  out  XW  horizontal count, XW = $clog2(H_TOTAL)
- y_o  out  YW  vertical count, YW = $clog2(V_TOTAL)
- line_start_o  out  1  one-clock pulse when x_o becomes 0
- frame_start_o  out  1  one-clock pulse when x_o and y_o both become 0

Behaviour:
- Derived values:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP
  - V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP
  - h sync region: H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC; v sync region analogous
- Elaboration-time assertion: every field >= 1 and CLK_DIV >= 1.
- Reset (async, rst_ni low), and also en_i low (synchronous, next edge):
  - div_cnt = 0; x = H_TOTAL-1; y = V_TOTAL-1
  - h_sync_o = ~H_SYNC_POL; v_sync_o = ~V_SYNC_POL
  - de_o, pix_en_o, line_start_o, frame_start_o = 0
  - x_o = H_TOTAL-1; y_o = V_TOTAL-1
- Divider: div_cnt counts 0..CLK_DIV-1 while en_i is high. Internal stb = (div_cnt == CLK_DIV-1); div_cnt wraps to 0 on stb.
- On an edge with stb:
  - x advances; at H_TOTAL-1 it wraps to 0 and y advances.
  - y wraps from V_TOTAL-1 to 0.
- All outputs are registered on that same edge from the new (x, y), so coordinates, sync, de and pulses are always mutually consistent.
- Latency: outputs change only on stb edges. pix_en_o is high for exactly the clock following each stb edge.
- line_start_o and frame_start_o are coincident with pix_en_o and last one clock.
- First frame after reset/enable:
  - First stb edge lands on (0,0) with frame_start_o = 1 and de_o = 1.
  - This occurs CLK_DIV clocks after the first enabled edge.
- en_i deasserted mid-frame: abort on the next edge to the reset state. No partial-line completion.
- CLK_DIV = 1: stb is continuously high and pix_en_o is constantly 1 while running.
- Sync and de are pure functions of the registered counters. No glitches; no combinational path from inputs to outputs.

Decomposition:
- Package vga_pkg:
  - typedef struct vga_timing_t {active, fp, sync, bp}
  - constants VGA_640x480_H / VGA_640x480_V and an 800x600 set
  - function timing_total()
- Sub-module pix_strobe_div (parameter CLK_DIV; ports clk_i, rst_ni, en_i, stb_o) holds the divider.
- Counters and output registers stay in vga_timing_gen.

Test Plan:
Bench parameters unless noted: H 8/2/3/3 (H_TOTAL 16), V 4/1/2/1 (V_TOTAL 8), CLK_DIV 2, both polarities 0.
- Reset release with en_i = 1:
  - Second edge is the first stb edge; first pix_en_o follows it with x_o = 0, y_o = 0, de_o = 1, frame_start_o = 1, line_start_o = 1.
  - Before that: outputs hold reset values, x_o = 15, y_o = 7.
- One full line:
  - de_o is high for x = 0..7 (16 clks).
  - h_sync_o is low for x = 10..12.
  - line_start_o pulses every 32 clks.
- Full frame:
  - v_sync_o is low for y = 5..6.
  - frame_start_o period is 256 clks; exactly 32 de pixels per frame.
- Polarity/divider variant (H_SYNC_POL = 1, V_SYNC_POL = 1, CLK_DIV = 1):
  - Syncs are active-high in the same regions; idle at reset = 0.
  - pix_en_o is constant 1; frame period is 128 clks.
- en_i dropped at x = 5, y = 2 for one clock:
  - Next edge returns to the reset state.
  - After re-enable, frame_start_o is seen after CLK_DIV clks.
- rst_ni asserted asynchronously mid-line (not on a clock edge):
  - All outputs take reset values immediately.
  - Resumes identically to the first scenario after release.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared raster timing types, standard mode presets and helper functions
// for the parametrised VGA timing generator.
package vga_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x480_H = '{active: 32'd640, fp: 32'd16, sync: 32'd96,  bp: 32'd48};
    localparam vga_timing_t VGA_640x480_V = '{active: 32'd480, fp: 32'd10, sync: 32'd2,   bp: 32'd33};
    localparam vga_timing_t VGA_800x600_H = '{active: 32'd800, fp: 32'd40, sync: 32'd128, bp: 32'd88};
    localparam vga_timing_t VGA_800x600_V = '{active: 32'd600, fp: 32'd1,  sync: 32'd4,   bp: 32'd23};

    function automatic int unsigned timing_total(input vga_timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/pix_strobe_div.sv
// Pixel clock-enable divider: stb_o marks the last system clock of each
// pixel period, so the timing counters advance once every CLK_DIV clocks.
module pix_strobe_div
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV = 32'd4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic stb_o
);

    localparam int unsigned DW = cnt_width(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 32'd1);

    logic [DW-1:0] div_cnt_r;
    logic          stb_s;

    // Strobe decode from the registered count only.
    always_comb begin
        stb_s = 1'b0;
        if (div_cnt_r == DIV_LAST) begin
            stb_s = 1'b1;
        end else begin
            stb_s = 1'b0;
        end
    end

    // Divider count, restarted whenever the generator is disabled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_r <= {DW{1'b0}};
        end else if (!en_i) begin
            div_cnt_r <= {DW{1'b0}};
        end else if (stb_s) begin
            div_cnt_r <= {DW{1'b0}};
        end else begin
            div_cnt_r <= div_cnt_r + DW'(1);
        end
    end

    assign stb_o = stb_s;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel/line counters advanced on a
// divided strobe, with every output registered from the new coordinates.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 32'd4,
    parameter int unsigned H_ACTIVE   = 32'd640,
    parameter int unsigned H_FP       = 32'd16,
    parameter int unsigned H_SYNC     = 32'd96,
    parameter int unsigned H_BP       = 32'd48,
    parameter int unsigned V_ACTIVE   = 32'd480,
    parameter int unsigned V_FP       = 32'd10,
    parameter int unsigned V_SYNC     = 32'd2,
    parameter int unsigned V_BP       = 32'd33,
    parameter bit          H_SYNC_POL = 1'b0,
    parameter bit          V_SYNC_POL = 1'b0,
    localparam vga_timing_t H_TIM   = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP},
    localparam vga_timing_t V_TIM   = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP},
    localparam int unsigned H_TOTAL = timing_total(H_TIM),
    localparam int unsigned V_TOTAL = timing_total(V_TIM),
    localparam int unsigned XW      = $clog2(H_TOTAL),
    localparam int unsigned YW      = $clog2(V_TOTAL)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    output logic          pix_en_o,
    output logic          h_sync_o,
    output logic          v_sync_o,
    output logic          de_o,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          line_start_o,
    output logic          frame_start_o
);

    if (CLK_DIV < 32'd1 || H_ACTIVE < 32'd1 || H_FP < 32'd1 || H_SYNC < 32'd1 ||
        H_BP < 32'd1 || V_ACTIVE < 32'd1 || V_FP < 32'd1 || V_SYNC < 32'd1 ||
        V_BP < 32'd1) begin : g_bad_params
        $error("vga_timing_gen: every timing field and CLK_DIV must be >= 1");
    end

    localparam logic [XW-1:0] X_LAST      = XW'(H_TOTAL - 32'd1);
    localparam logic [XW-1:0] X_ACT_END   = XW'(H_ACTIVE);
    localparam logic [XW-1:0] X_SYNC_BEG  = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] X_SYNC_END  = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] Y_LAST      = YW'(V_TOTAL - 32'd1);
    localparam logic [YW-1:0] Y_ACT_END   = YW'(V_ACTIVE);
    localparam logic [YW-1:0] Y_SYNC_BEG  = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] Y_SYNC_END  = YW'(V_ACTIVE + V_FP + V_SYNC);

    logic          stb_s;
    logic [XW-1:0] x_nxt_s;
    logic [YW-1:0] y_nxt_s;
    logic          h_sync_nxt_s;
    logic          v_sync_nxt_s;
    logic          de_nxt_s;
    logic          line_start_nxt_s;
    logic          frame_start_nxt_s;

    logic [XW-1:0] x_r;
    logic [YW-1:0] y_r;
    logic          h_sync_r;
    logic          v_sync_r;
    logic          de_r;
    logic          pix_en_r;
    logic          line_start_r;
    logic          frame_start_r;

    pix_strobe_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (en_i),
        .stb_o  (stb_s)
    );

    // Raster position that the next strobe moves to.
    always_comb begin
        x_nxt_s = x_r;
        y_nxt_s = y_r;
        if (x_r == X_LAST) begin
            x_nxt_s = {XW{1'b0}};
            if (y_r == Y_LAST) begin
                y_nxt_s = {YW{1'b0}};
            end else begin
                y_nxt_s = y_r + YW'(1);
            end
        end else begin
            x_nxt_s = x_r + XW'(1);
        end
    end

    // Sync, display enable and pulse levels decoded from the next position,
    // so the registered outputs always agree with the registered coordinates.
    always_comb begin
        h_sync_nxt_s      = ~H_SYNC_POL;
        v_sync_nxt_s      = ~V_SYNC_POL;
        de_nxt_s          = 1'b0;
        line_start_nxt_s  = 1'b0;
        frame_start_nxt_s = 1'b0;
        if (x_nxt_s >= X_SYNC_BEG && x_nxt_s < X_SYNC_END) begin
            h_sync_nxt_s = H_SYNC_POL;
        end else begin
            h_sync_nxt_s = ~H_SYNC_POL;
        end
        if (y_nxt_s >= Y_SYNC_BEG && y_nxt_s < Y_SYNC_END) begin
            v_sync_nxt_s = V_SYNC_POL;
        end else begin
            v_sync_nxt_s = ~V_SYNC_POL;
        end
        if (x_nxt_s < X_ACT_END && y_nxt_s < Y_ACT_END) begin
            de_nxt_s = 1'b1;
        end else begin
            de_nxt_s = 1'b0;
        end
        if (x_nxt_s == {XW{1'b0}}) begin
            line_start_nxt_s  = 1'b1;
            frame_start_nxt_s = (y_nxt_s == {YW{1'b0}});
        end else begin
            line_start_nxt_s  = 1'b0;
            frame_start_nxt_s = 1'b0;
        end
    end

    // Counter and output registers; disabling parks everything at the
    // last position so the first strobe after enabling lands on (0,0).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_r           <= X_LAST;
            y_r           <= Y_LAST;
            h_sync_r      <= ~H_SYNC_POL;
            v_sync_r      <= ~V_SYNC_POL;
            de_r          <= 1'b0;
            pix_en_r      <= 1'b0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else if (!en_i) begin
            x_r           <= X_LAST;
            y_r           <= Y_LAST;
            h_sync_r      <= ~H_SYNC_POL;
            v_sync_r      <= ~V_SYNC_POL;
            de_r          <= 1'b0;
            pix_en_r      <= 1'b0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else if (stb_s) begin
            x_r           <= x_nxt_s;
            y_r           <= y_nxt_s;
            h_sync_r      <= h_sync_nxt_s;
            v_sync_r      <= v_sync_nxt_s;
            de_r          <= de_nxt_s;
            pix_en_r      <= 1'b1;
            line_start_r  <= line_start_nxt_s;
            frame_start_r <= frame_start_nxt_s;
        end else begin
            pix_en_r      <= 1'b0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end
    end

    assign pix_en_o      = pix_en_r;
    assign h_sync_o      = h_sync_r;
    assign v_sync_o      = v_sync_r;
    assign de_o          = de_r;
    assign x_o           = x_r;
    assign y_o           = y_r;
    assign line_start_o  = line_start_r;
    assign frame_start_o = frame_start_r;

endmodule
